// File: rtl/req_encoder8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : req_enc_pkg
// Purpose  : Shared constants and helpers for the 8-to-3 request encoder.
//            onehot_of() is the 3-to-8 decoder model: it regenerates the
//            one-hot request line from an emitted code.
// Revision : 1.0  initial release
// ============================================================================
package req_enc_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;
  localparam int CNT_W  = 4;

  function automatic logic [N_REQ-1:0] onehot_of(input logic [CODE_W-1:0] c);
    logic [N_REQ-1:0] oh;
    oh    = '0;
    oh[c] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/req_encoder8_if.sv
`default_nettype none
// ============================================================================
// Module   : req_encoder8_if
// Purpose  : Output handshake of the request encoder.
// Signals  : code  - emitted request index
//            valid - code is valid
//            ready - consumer accepts code when valid && ready at a clock edge
// Modports : master - encoder side (drives code/valid, observes ready)
//            slave  - consumer side (observes code/valid, drives ready)
// Revision : 1.0  initial release
// ============================================================================
interface req_encoder8_if;
  import req_enc_pkg::*;

  logic [CODE_W-1:0] code;
  logic              valid;
  logic              ready;

  modport master (output code, output valid, input ready);
  modport slave  (input code, input valid, output ready);

endinterface
`default_nettype wire

// File: rtl/req_encoder8_prio_enc8.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc8
// Purpose  : Combinational 8-input priority encoder, highest index wins.
// Ports    : vec - input vector
//            idx - index of the highest set bit (0 when vec is zero)
//            any - at least one bit of vec is set
// Revision : 1.0  initial release
// ============================================================================
module prio_enc8
  import req_enc_pkg::*;
(
  input  logic [N_REQ-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Ascending scan: a later (higher) set bit overwrites earlier ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) idx = CODE_W'(i);
    end
  end

  assign any = |vec;

endmodule
`default_nettype wire

// File: rtl/req_encoder8.sv
`default_nettype none
// ============================================================================
// Module   : req_encoder8
// Purpose  : Sequential 8-to-3 request encoder. Request events are latched
//            into a pending set and emitted one at a time as 3-bit codes
//            through a valid/ready handshake, highest index first.
// Params   : EDGE     - 1: capture rising edges of req, 0: capture req level
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            req      - request lines, bit i requests code i
//            ovf      - sticky per-line overflow flags
//            ovf_clr  - synchronous clear of all ovf bits
//            pend_cnt - number of pending requests (0..8)
//            enc      - output handshake (code, valid, ready)
// Revision : 1.0  initial release
// ============================================================================
module req_encoder8
  import req_enc_pkg::*;
#(
  parameter int EDGE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic               ovf_clr,
  output logic [N_REQ-1:0]   ovf,
  output logic [CNT_W-1:0]   pend_cnt,
  req_encoder8_if.master     enc
);

  logic [N_REQ-1:0]  req_d;
  logic [N_REQ-1:0]  pending;
  logic [CODE_W-1:0] out_code;
  logic              out_valid;

  logic [N_REQ-1:0]  capture;
  logic              load;
  logic [CODE_W-1:0] sel;
  logic              sel_any;
  logic [N_REQ-1:0]  load_oh;
  logic [N_REQ-1:0]  pending_nxt;
  logic [N_REQ-1:0]  ovf_set;
  logic [N_REQ-1:0]  ovf_nxt;

  assign capture = (EDGE != 0) ? (req & ~req_d) : req;

  // Output register may take a new code when empty or being accepted now.
  assign load = !out_valid || enc.ready;

  prio_enc8 u_prio (
    .vec (pending),
    .idx (sel),
    .any (sel_any)
  );

  assign load_oh = (load && sel_any) ? onehot_of(sel) : '0;

  // Capture is ORed after the clear so a new event on the bit being loaded
  // remains pending rather than being absorbed by the load.
  assign pending_nxt = (pending & ~load_oh) | capture;

  // A capture onto an already-pending bit that is not leaving this cycle
  // merges two events into one: flag it.
  assign ovf_set = capture & pending & ~load_oh;

  // Clear first, then set, so a coincident overflow survives ovf_clr.
  assign ovf_nxt = (ovf_clr ? '0 : ovf) | ovf_set;

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pend_cnt = pend_cnt + CNT_W'(pending[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d     <= '0;
      pending   <= '0;
      out_code  <= '0;
      out_valid <= 1'b0;
      ovf       <= '0;
    end else begin
      req_d   <= req;
      pending <= pending_nxt;
      ovf     <= ovf_nxt;
      if (load) begin
        if (sel_any) begin
          out_code  <= sel;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign enc.code  = out_code;
  assign enc.valid = out_valid;

endmodule
`default_nettype wire

// File: tb/tb_req_encoder8.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_encoder8
// Purpose  : Self-checking bench for req_encoder8. One instance in edge mode,
//            one in level mode. Directed stimulus pushes expected codes into
//            per-instance queues; a monitor pops and compares on every
//            accepted handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_req_encoder8;
  import req_enc_pkg::*;

  logic clk;
  logic rst_n;

  // Edge-mode instance
  logic [7:0] req1;
  logic       ovf_clr1;
  logic [7:0] ovf1;
  logic [3:0] cnt1;
  req_encoder8_if if1 ();

  // Level-mode instance
  logic [7:0] req0;
  logic       ovf_clr0;
  logic [7:0] ovf0;
  logic [3:0] cnt0;
  req_encoder8_if if0 ();

  req_encoder8 #(.EDGE(1)) u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req1),
    .ovf_clr  (ovf_clr1),
    .ovf      (ovf1),
    .pend_cnt (cnt1),
    .enc      (if1)
  );

  req_encoder8 #(.EDGE(0)) u_level (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req0),
    .ovf_clr  (ovf_clr0),
    .ovf      (ovf0),
    .pend_cnt (cnt0),
    .enc      (if0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [2:0] q1[$];
  logic [2:0] q0[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Inputs change and outputs are checked 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: on the falling edge, a valid && ready pair will be
  // accepted at the next rising edge, so the code must match the queue head.
  always @(negedge clk) begin
    if (if1.valid && if1.ready) begin
      if (q1.size() == 0) begin
        total++;
        $display("FAIL sb_edge: got unexpected code %0d expected none at %0t", if1.code, $time);
      end else begin
        chk("sb_edge_code", 32'(if1.code), 32'(q1.pop_front()));
      end
    end
    if (if0.valid && if0.ready) begin
      if (q0.size() == 0) begin
        total++;
        $display("FAIL sb_level: got unexpected code %0d expected none at %0t", if0.code, $time);
      end else begin
        chk("sb_level_code", 32'(if0.code), 32'(q0.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req1      = 8'hFF;
    ovf_clr1  = 1'b0;
    if1.ready = 1'b1;
    req0      = 8'h00;
    ovf_clr0  = 1'b0;
    if0.ready = 1'b0;

    // ---------------- Reset sweep ----------------
    step();
    step();
    chk("rst_valid", 32'(if1.valid), 0);
    chk("rst_code",  32'(if1.code),  0);
    chk("rst_ovf",   32'(ovf1),      0);
    chk("rst_cnt",   32'(cnt1),      0);
    for (int k = 7; k >= 0; k--) q1.push_back(3'(k));
    rst_n = 1'b1;
    step();
    chk("sweep_valid_e1", 32'(if1.valid), 0);
    chk("sweep_cnt_e1",   32'(cnt1),      8);
    for (int k = 7; k >= 0; k--) begin
      step();
      chk("sweep_valid", 32'(if1.valid), 1);
      chk("sweep_code",  32'(if1.code),  32'(k));
      chk("sweep_cnt",   32'(cnt1),      32'(k));
      chk("sweep_ovf",   32'(ovf1),      0);
    end
    req1 = 8'h00;
    step();
    chk("sweep_end_valid", 32'(if1.valid), 0);

    // ---------------- Backpressure ----------------
    if1.ready = 1'b0;
    q1.push_back(3'd2);
    q1.push_back(3'd5);
    req1 = 8'h04;
    step();
    req1 = 8'h00;
    step();
    chk("bp_code_c", 32'(if1.code), 2);
    req1 = 8'h20;
    step();
    req1 = 8'h00;
    chk("bp_valid_d", 32'(if1.valid), 1);
    chk("bp_code_d",  32'(if1.code),  2);
    chk("bp_cnt_d",   32'(cnt1),      1);
    step();
    chk("bp_code_e",  32'(if1.code),  2);
    chk("bp_cnt_e",   32'(cnt1),      1);
    if1.ready = 1'b1;
    step();
    chk("bp_code_f",  32'(if1.code),  5);
    step();
    chk("bp_end_valid", 32'(if1.valid), 0);

    // ---------------- Overflow ----------------
    if1.ready = 1'b0;
    q1.push_back(3'd3);
    q1.push_back(3'd3);
    req1 = 8'h08; step();   // B: pending[3]
    req1 = 8'h00; step();   // C: code 3 loaded
    chk("ovf_code_c", 32'(if1.code), 3);
    req1 = 8'h08; step();   // D: pending[3] again
    chk("ovf_none_d", 32'(ovf1), 0);
    chk("ovf_cnt_d",  32'(cnt1), 1);
    req1 = 8'h00; step();   // E
    req1 = 8'h08; step();   // F: third pulse overflows
    chk("ovf_set",     32'(ovf1), 8'h08);
    chk("ovf_set_cnt", 32'(cnt1), 1);
    req1 = 8'h00; ovf_clr1 = 1'b1; step();   // G: clear
    chk("ovf_clr", 32'(ovf1), 0);
    req1 = 8'h08; ovf_clr1 = 1'b1; step();   // H: clear and new overflow
    chk("ovf_clr_vs_set", 32'(ovf1), 8'h08);
    req1 = 8'h00; ovf_clr1 = 1'b1; step();
    ovf_clr1 = 1'b0;
    chk("ovf_clr2", 32'(ovf1), 0);
    if1.ready = 1'b1;
    step();
    step();
    chk("ovf_drain_valid", 32'(if1.valid), 0);

    // ---------------- Same-bit recapture ----------------
    if1.ready = 1'b0;
    q1.push_back(3'd6);
    q1.push_back(3'd4);
    q1.push_back(3'd4);
    req1 = 8'h40; step();   // B: pending[6]
    req1 = 8'h00; step();   // C: code 6 loaded
    req1 = 8'h10; step();   // D: pending = 8'h10
    chk("rc_cnt_d", 32'(cnt1), 1);
    req1 = 8'h00; step();   // E
    req1 = 8'h10; if1.ready = 1'b1; step();   // F: load 4 and recapture 4
    req1 = 8'h00;
    chk("rc_code_f", 32'(if1.code), 4);
    chk("rc_cnt_f",  32'(cnt1),     1);
    chk("rc_ovf_f",  32'(ovf1),     0);
    step();
    chk("rc_code_g",  32'(if1.code),  4);
    chk("rc_valid_g", 32'(if1.valid), 1);
    step();
    chk("rc_end_valid", 32'(if1.valid), 0);
    chk("rc_end_ovf",   32'(ovf1),      0);

    // ---------------- Async reset mid-run ----------------
    if1.ready = 1'b0;
    req1 = 8'h80; step();
    req1 = 8'h00; step();   // code 7 in output
    req1 = 8'h24; step();   // pending = 8'h24
    req1 = 8'h00; step();
    req1 = 8'h04; step();   // overflow on line 2
    req1 = 8'h00;
    chk("ar_pre_valid", 32'(if1.valid), 1);
    chk("ar_pre_cnt",   32'(cnt1),      2);
    chk("ar_pre_ovf",   32'(ovf1),      8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(if1.valid), 0);
    chk("ar_code",  32'(if1.code),  0);
    chk("ar_ovf",   32'(ovf1),      0);
    chk("ar_cnt",   32'(cnt1),      0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ar_post_valid", 32'(if1.valid), 0);
    end

    // ---------------- Level mode ----------------
    if0.ready = 1'b1;
    for (int k = 0; k < 4; k++) q0.push_back(3'd1);
    req0 = 8'h02;
    step();                 // B: pending[1]
    chk("lv_valid_b", 32'(if0.valid), 0);
    step();                 // C: code 1
    chk("lv_valid_c", 32'(if0.valid), 1);
    chk("lv_code_c",  32'(if0.code),  1);
    step();                 // D
    step();                 // E
    req0 = 8'h00;
    step();                 // F: last code 1
    chk("lv_valid_f", 32'(if0.valid), 1);
    step();                 // G
    chk("lv_end_valid", 32'(if0.valid), 0);
    chk("lv_end_ovf",   32'(ovf0),      0);

    if0.ready = 1'b0;
    q0.push_back(3'd1);
    q0.push_back(3'd1);
    req0 = 8'h02;
    step();                 // pending[1]
    chk("lv_bp_cnt", 32'(cnt0), 1);
    step();                 // loaded and recaptured, no overflow
    chk("lv_bp_ovf_c", 32'(ovf0), 0);
    step();                 // stalled: overflow
    chk("lv_bp_ovf_d", 32'(ovf0), 8'h02);
    req0 = 8'h00; if0.ready = 1'b1; ovf_clr0 = 1'b1;
    step();
    ovf_clr0 = 1'b0;
    chk("lv_clr", 32'(ovf0), 0);
    step();
    chk("lv_drain_valid", 32'(if0.valid), 0);

    step();
    chk("q_edge_empty",  32'(q1.size()), 0);
    chk("q_level_empty", 32'(q0.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/req_encoder8.md
# req_encoder8

Sequential 8-to-3 request encoder. It is the inverse of the team's 3-to-8 one-hot decoder: eight request lines are latched into a pending set, and each request is emitted as a 3-bit index code through a valid/ready handshake. Selection among pending requests is fixed priority, highest index first. Downstream logic can drive the decoder with the emitted code to regenerate the one-hot line.

## Interface
Parameters:
- EDGE, default 1. 1: capture rising edges of each req bit. 0: capture req level every cycle.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  8  request lines; bit i requests code i
- code  output  3  index of the emitted request, registered
- valid  output  1  code is valid, registered
- ready  input  1  consumer accepts code when valid && ready at a clock edge
- ovf  output  8  sticky per-line overflow flags, registered
- ovf_clr  input  1  synchronous clear of all ovf bits
- pend_cnt  output  4  number of set pending bits, 0..8, combinational popcount of pending

## Operation
- req_d: previous-cycle copy of req, registered.
- capture = EDGE ? (req & ~req_d) : req.
- load: output stage is empty or draining, i.e. !valid || ready.
- sel: highest set index of pending. load_oh: one-hot of sel when load && |pending, else 0.
- pending next = (pending & ~load_oh) | capture. If a capture hits the bit being loaded in the same cycle, the capture wins: the bit stays pending as a new event.
- Output stage:
  - load && |pending: code <= sel, valid <= 1.
  - load && pending==0: valid <= 0, code holds.
  - !load: code and valid hold, stable under backpressure.
- A code already in the output register is never pre-empted by a higher-priority arrival.
- Overflow: ovf[i] sets when capture[i] && pending[i] && !load_oh[i]. That event is lost and counts as one request.
- ovf_clr has lower precedence than a set in the same cycle, so a simultaneous new overflow leaves the bit set.
- Any request line may be captured while its own code sits in the output register. It becomes pending normally and is not an overflow.

## Timing
- Reset values: code=0, valid=0, ovf=0, pending=0, req_d=0, pend_cnt=0.
- Reset asserts asynchronously and releases synchronously through the flops. Because req_d resets to 0, with EDGE=1 a req bit held high through reset release is captured at the first clock edge.
- Latency: req sampled at edge k sets pending after edge k. With the output stage idle or draining, valid/code appear after edge k+1, a 2-cycle latency.
- Throughput: one code per cycle while ready=1 and pending is non-zero.
- An accepted code is replaced by the next pending code on the same edge, with no bubble.
- When both are possible in one cycle, all eight lines are captured and one is loaded on the same edge.
- Asserting rst_n mid-operation discards pending and the output stage immediately, without waiting for a clock.

## Structure
- Package req_enc_pkg holds:
  - constants N_REQ=8, CODE_W=3, CNT_W=4
  - function onehot_of(code) returning an 8-bit one-hot, used for load_oh and by benches as the decoder model
- Sub-module prio_enc8: combinational. Input 8-bit vector; outputs 3-bit index of the highest set bit and an any flag. It is instantiated once on pending.
- The top module holds req_d, pending, the output stage, ovf and the popcount.

## Test plan
- Reset sweep (EDGE=1): hold req=8'hFF across reset release, ready=1.
  - valid first rises 2 edges after release.
  - Codes follow 7,6,5,4,3,2,1,0 on consecutive cycles, then valid=0.
  - pend_cnt counts 8,7,...,0 and ovf stays 0.
- Backpressure: ready=0, 1-cycle pulse on req[2], then a pulse on req[5] two cycles later.
  - code=2 with valid=1 holds while stalled; pend_cnt=1.
  - Raising ready emits 2, then 5, then valid=0.
- Overflow: ready=0, pulse req[3] three times, two cycles apart.
  - First pulse loads code=3; second sets pending[3].
  - Third sets ovf=8'h08 with pend_cnt=1.
  - ovf_clr for one cycle returns ovf to 0.
  - ovf_clr coincident with a fourth pulse leaves ovf=8'h08.
- Same-bit recapture: pending=8'h10, ready=1, pulse req[4] on the cycle code 4 is loaded.
  - Code 4 is emitted twice on consecutive cycles; ovf=0.
- Async reset mid-run: with valid=1 and pending=8'h24, drop rst_n between clock edges.
  - valid, code, ovf and pend_cnt read 0 before the next edge.
  - After release with req=0, valid stays 0.
- Level mode (EDGE=0): hold req[1] high for 4 cycles with ready=1.
  - Code 1 is emitted on consecutive cycles starting 2 edges after assertion, and ovf stays 0.
  - With ready=0 and req[1] held, ovf[1] sets on the cycle after pending[1] sets.
